debouncer_bank: RTL and testbench

- Parametrised N-channel switch debouncer for the music-player front panel; supersedes the single-key two-flop edge detector.
- Per key: two-flop synchroniser, stable-count filter qualified by a shared sample tick, debounced level, one-clock press/release pulses, and optional hold-to-repeat pulses for volume/seek keys.
- Sits between the raw push-button pins and the player control FSM.

---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 144 ++++++++++++++
 rtl/debouncer_bank.sv | 46 ++++
 tb/tb_debouncer_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the front-panel key debouncer bank.
// Holds the repeat state encoding, a safe counter-width helper and default timing.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_e;

    // Default timing assumes a 1 kHz sample tick from the player timebase.
    localparam int TICK_HZ          = 32'sd1000;
    localparam int DEF_STABLE_CNT   = 32'sd4;
    localparam int DEF_REPEAT_DELAY = (TICK_HZ * 32'sd32) / 32'sd1000;
    localparam int DEF_REPEAT_RATE  = (TICK_HZ * 32'sd8) / 32'sd1000;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int safe_width(input int v);
        int w;
        w = 32'sd1;
        while ((32'sd1 <<< w) < v) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: two-flop synchroniser, tick-qualified stable-count filter,
// registered press/release pulses and the hold-to-repeat state machine.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int ACTIVE_LOW   = 32'sd1,
    parameter int REPEAT_EN    = 32'sd1,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic k,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = safe_width(STABLE_CNT);
    localparam int RW   = safe_width(RMAX);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 32'sd1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 32'sd1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 32'sd1);
    localparam logic          POL        = (ACTIVE_LOW != 32'sd0);
    localparam logic          RPT_ON     = (REPEAT_EN != 32'sd0);

    logic          s1_r;
    logic          s2_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          repeat_r;
    rpt_state_e    state_r;
    logic [RW-1:0] rcnt_r;
    logic          flip_s;
    logic          rise_s;
    logic          fall_s;

    // Level flips on the tick that completes the run of mismatching samples.
    always_comb begin
        flip_s = 1'b0;
        if (ena && (s2_r != level_r) && (cnt_r == CNT_LAST)) begin
            flip_s = 1'b1;
        end else begin
            flip_s = 1'b0;
        end
        rise_s = flip_s & s2_r;
        fall_s = flip_s & ~s2_r;
    end

    // Synchroniser resets to "released" so a key held through reset is re-debounced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= k ^ POL;
            s2_r <= s1_r;
        end
    end

    // Stable-count filter and the press/release pulses it produces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= rise_s;
            release_r <= fall_s;
            if (ena) begin
                if (s2_r == level_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == CNT_LAST) begin
                    level_r <= s2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Auto-repeat; a release on the terminal tick wins over the repeat pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            rcnt_r   <= '0;
            repeat_r <= 1'b0;
        end else begin
            repeat_r <= 1'b0;
            if (fall_s || !RPT_ON) begin
                state_r <= IDLE;
                rcnt_r  <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (rise_s) begin
                            state_r <= DELAY;
                            rcnt_r  <= '0;
                        end
                    end
                    DELAY: begin
                        if (ena) begin
                            if (rcnt_r == DELAY_LAST) begin
                                repeat_r <= 1'b1;
                                state_r  <= RPT;
                                rcnt_r   <= '0;
                            end else begin
                                rcnt_r <= rcnt_r + {{(RW-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    RPT: begin
                        if (ena) begin
                            if (rcnt_r == RATE_LAST) begin
                                repeat_r <= 1'b1;
                                rcnt_r   <= '0;
                            end else begin
                                rcnt_r <= rcnt_r + {{(RW-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        rcnt_r  <= '0;
                    end
                endcase
            end
        end
    end

    assign key_level   = level_r;
    assign key_press   = press_r;
    assign key_release = release_r;
    assign key_repeat  = repeat_r;

endmodule

// File: rtl/debouncer_bank.sv
// N independent debounced key channels for the front panel, plus a
// combined press flag for waking the player control FSM.
module debouncer_bank
    import debounce_pkg::*;
#(
    parameter int N_KEYS       = 32'sd4,
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int ACTIVE_LOW   = 32'sd1,
    parameter int REPEAT_EN    = 32'sd1,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [N_KEYS-1:0] k,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_press
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT   (STABLE_CNT),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .ena         (ena),
            .k           (k[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_repeat  (key_repeat[i])
        );
    end

    // Built from already-registered pulses, so no extra cycle of latency.
    assign any_press = |key_press;

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench for debouncer_bank: reset/debounce vector table, hand-written
// corner sequences and a randomized run against a window-based reference model.
module tb_debouncer_bank;

    localparam int NK = 4;
    localparam int SC = 4;
    localparam int RD = 8;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [NK-1:0] k;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_repeat;
    logic          any_press;

    int n_checks = 0;
    int n_fail   = 0;

    debouncer_bank #(
        .N_KEYS(NK), .STABLE_CNT(SC), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .k(k),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .any_press(any_press)
    );

    always #5 clk = ~clk;

    // Reference model: pressed-history queue, last SC tick samples per key,
    // and tick count since the press.
    logic [NK-1:0] hist_q[$];
    logic [SC-1:0] win[NK];
    int            ticks[NK];
    logic [NK-1:0] e_lvl, e_press, e_rel, e_rpt;

    task automatic model_reset();
        hist_q.delete();
        for (int c = 0; c < NK; c++) begin
            win[c]   = '0;
            ticks[c] = 0;
        end
        e_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0;
    endtask

    task automatic model_edge();
        logic [NK-1:0] samp;
        e_press = '0; e_rel = '0; e_rpt = '0;
        if (rst) begin
            model_reset();
        end else begin
            hist_q.push_back(~k);
            if (hist_q.size() > 3) hist_q.delete(0);
            samp = (hist_q.size() == 3) ? hist_q[0] : '0;
            for (int c = 0; c < NK; c++) begin
                if (ena) begin
                    win[c] = {samp[c], win[c][SC-1:1]};
                    if (win[c] == (e_lvl[c] ? {SC{1'b0}} : {SC{1'b1}})) begin
                        e_lvl[c] = ~e_lvl[c];
                        if (e_lvl[c]) begin
                            e_press[c] = 1'b1;
                            ticks[c]   = 0;
                        end else begin
                            e_rel[c] = 1'b1;
                        end
                    end else if (e_lvl[c]) begin
                        ticks[c]++;
                        if (ticks[c] == RD || (ticks[c] > RD && ((ticks[c] - RD) % RR) == 0))
                            e_rpt[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input string name);
        model_edge();
        @(posedge clk);
        #1;
        check(name, {key_level, key_press, key_release, key_repeat, any_press},
              {e_lvl, e_press, e_rel, e_rpt, |e_press});
    endtask

    task automatic settle(input int n);
        k = '1; ena = 1'b1; rst = 1'b0;
        for (int i = 0; i < n; i++) step("settle");
    endtask

    typedef struct packed {
        logic          rst;
        logic [NK-1:0] k;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t tbl[15];

    initial begin
        rst = 1'b1; ena = 1'b1; k = '1;
        model_reset();

        tbl[0]  = {1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = {1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 2; i <= 6; i++) tbl[i] = {1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[7]  = {1'b0, 4'h0, 4'hF, 4'hF, 4'h0};
        for (int i = 8; i <= 12; i++) tbl[i] = {1'b0, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[13] = {1'b0, 4'hF, 4'h0, 4'h0, 4'hF};
        tbl[14] = {1'b0, 4'hF, 4'h0, 4'h0, 4'h0};

        // Reset hold, then release into held keys: press on edge 6, release 5 edges after letting go.
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; k = tbl[i].k; ena = 1'b1;
            step("tbl_model");
            check($sformatf("tbl_row%0d", i), {key_level, key_press, key_release, key_repeat},
                  {tbl[i].lvl, tbl[i].prs, tbl[i].rel, 4'h0});
        end
        settle(4);

        // Bounce on k[0] never completes a run of four samples.
        begin
            logic [5:0] bounce;
            bounce = 6'b100101;
            for (int i = 0; i < 6; i++) begin
                k[0] = bounce[i];
                step("bounce_model");
                check("bounce_no_press", key_press[0], 1'b0);
            end
        end
        k[0] = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            step("steady_model");
            check("steady_press", key_press[0], (i == 5));
            check("steady_level", key_level[0], (i >= 5));
        end
        settle(20);

        // Tick every third clock: four qualified samples needed.
        k[1] = 1'b0;
        for (int i = 0; i <= 14; i++) begin
            ena = (i % 3 == 0);
            step("gate_model");
            check("gate_press", key_press[1], (i == 12));
        end
        // Release, count two samples, freeze, then re-press: count is discarded.
        k[1] = 1'b1; ena = 1'b1;
        for (int i = 0; i < 4; i++) step("freeze_model");
        ena = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) k[1] = 1'b0;
            step("freeze_model");
            check("freeze_level", key_level[1], 1'b1);
        end
        ena = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("freeze_model");
            check("freeze_no_flip", {key_level[1], key_release[1]}, 2'b10);
        end
        // Release again; the frozen count resumes after the idle gap.
        k[1] = 1'b1;
        for (int i = 0; i < 4; i++) step("resume_model");
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("resume_model");
            check("resume_hold", key_release[1], 1'b0);
        end
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("resume_model");
            check("resume_release", key_release[1], (i == 1));
        end
        settle(20);

        // Auto-repeat on k[2]: press at 5, repeats at 13/16/19, release on 22 suppresses repeat.
        k[2] = 1'b0;
        for (int i = 0; i <= 27; i++) begin
            if (i == 17) k[2] = 1'b1;
            step("rpt_model");
            check("rpt_pulses", {key_press[2], key_release[2], key_repeat[2]},
                  {(i == 5), (i == 22), (i == 13 || i == 16 || i == 19)});
        end
        settle(6);

        // Two keys pressed together, held into repeat, then async reset mid-cycle.
        k = 4'b0101;
        for (int i = 0; i <= 15; i++) begin
            step("multi_model");
            check("multi_press", {key_press, any_press}, {((i == 5) ? 4'b1010 : 4'b0000), (i == 5)});
        end
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_zero", {key_level, key_press, key_release, key_repeat, any_press}, 17'h0);
        model_reset();
        step("rst_hold_model");
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step("post_rst_model");
            check("post_rst_pulses", {key_press, key_release, key_repeat},
                  {((i == 6) ? 4'b1010 : 4'b0000), 4'h0, 4'h0});
        end
        settle(12);

        // Randomized run with sticky key toggles, random ticks and rare resets.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, 5) == 0) k[b] = ~k[b];
            ena = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 599) == 0);
            step("random_model");
        end
        rst = 1'b0;
        settle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
